// File: rtl/serial_pattern_feeder.sv
// serial_pattern_feeder: debounced step/load buttons drive a serial pattern
// bit-by-bit, each followed by a clean stretched shift clock for the detector.
module serial_pattern_feeder #(
  parameter int DEB_CYCLES = 500000,
  parameter int STEP_HIGH  = 25000000
) (
  input  logic        CLOCK_50,
  input  logic [17:0] SW,
  input  logic [3:0]  KEY,
  output logic        ser_out,
  output logic        step_clk,
  output logic [17:0] LEDR
);

  typedef enum logic [1:0] {
    EMPTY,
    READY,
    DONE
  } state_t;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);
  localparam int HW = $clog2(STEP_HIGH + 1);
  localparam logic [HW-1:0] HMAX = HW'(STEP_HIGH - 1);

  logic rst_n;
  assign rst_n = SW[17];

  logic unused_ok;
  assign unused_ok = ^{KEY[1:0], SW[16:9]};

  logic [1:0] raw;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] press;
  assign raw = KEY[3:2];

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 2'b11;
      s2 <= 2'b11;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // press[1] = step, press[0] = load
  for (genvar b = 0; b < 2; b++) begin : g_deb
    logic [DW-1:0] cnt;
    logic          deb;
    logic          diff;
    logic          hit;

    assign diff = s2[b] != deb;
    assign hit = diff && (cnt == DMAX);
    // pulse in the cycle the debounced level is about to fall
    assign press[b] = hit && deb;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        deb <= 1'b1;
      end else if (!diff) begin
        cnt <= '0;
      end else if (hit) begin
        cnt <= '0;
        deb <= s2[b];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  logic step_p;
  logic load_p;
  assign step_p = press[1];
  assign load_p = press[0];

  state_t        state;
  state_t        nstate;
  logic [7:0]    pat;
  logic [7:0]    shreg;
  logic [3:0]    left;
  logic [HW-1:0] hcnt;
  logic          arm;
  logic          busy;
  logic          do_load;
  logic          do_step;
  logic          do_loop;

  assign busy = step_clk | arm;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (1'b1)
      do_load: nstate = READY;
      do_step: nstate = (left == 4'd1) ? DONE : READY;
      do_loop: nstate = READY;
      default: nstate = state;
    endcase
  end

  always_comb begin
    do_load = load_p;
    do_step = 1'b0;
    do_loop = 1'b0;
    if (step_p && !load_p && !busy) begin
      unique case (state)
        READY:   do_step = 1'b1;
        DONE:    do_loop = SW[8];
        default: do_step = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pat     <= '0;
      shreg   <= '0;
      left    <= '0;
      ser_out <= 1'b0;
    end else if (do_load) begin
      pat   <= SW[7:0];
      shreg <= SW[7:0];
      left  <= 4'd8;
    end else if (do_step) begin
      ser_out <= shreg[7];
      shreg   <= {shreg[6:0], 1'b0};
      left    <= left - 4'd1;
    end else if (do_loop) begin
      ser_out <= pat[7];
      shreg   <= {pat[6:0], 1'b0};
      left    <= 4'd7;
    end
  end

  // one idle cycle between data update and the clock rise
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      arm      <= 1'b0;
      step_clk <= 1'b0;
      hcnt     <= '0;
    end else begin
      arm <= do_step | do_loop;
      if (arm) begin
        step_clk <= 1'b1;
        hcnt     <= '0;
      end else if (step_clk) begin
        if (hcnt == HMAX) step_clk <= 1'b0;
        else              hcnt <= hcnt + 1'b1;
      end
    end
  end

  assign LEDR = {state == DONE, step_clk, 4'b0000, left, shreg};

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Bench for serial_pattern_feeder: transaction-level model of the feeder
// checked every cycle, plus directed literal expectations.
module tb_serial_pattern_feeder;

  localparam int DEB  = 4;
  localparam int SH   = 3;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic [17:0] sw;
  logic [3:0]  key;
  logic        ser_out;
  logic        step_clk;
  logic [17:0] ledr;

  int n_tests = 0;
  int n_fail  = 0;

  serial_pattern_feeder #(
    .DEB_CYCLES(DEB),
    .STEP_HIGH (SH)
  ) dut (
    .CLOCK_50(clk),
    .SW      (sw),
    .KEY     (key),
    .ser_out (ser_out),
    .step_clk(step_clk),
    .LEDR    (ledr)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: raw key history, debounced levels, queue of pending bits
  int  cyc = 0;
  bit  h3[MAXC];
  bit  h2[MAXC];
  bit  lv3 = 1'b1;
  bit  lv2 = 1'b1;
  bit  m_loaded = 1'b0;
  bit  mq[$];
  bit  [7:0] m_pat = '0;
  bit  m_ser = 1'b0;
  int  clk_start = -100;

  function automatic bit settled(input int n, input bit lvl, input bit b3);
    for (int i = n - DEB; i < n; i++) begin
      bit v;
      v = (i < 0) ? 1'b1 : (b3 ? h3[i] : h2[i]);
      if (v == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [7:0] m_sh();
    logic [7:0] v;
    v = '0;
    foreach (mq[i]) v[7-i] = mq[i];
    return v;
  endfunction

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      h3[i] = 1'b1;
      h2[i] = 1'b1;
    end
    forever begin
      int n;
      bit p3;
      bit p2;
      @(posedge clk);
      cyc++;
      if (cyc >= MAXC) begin
        $display("FAIL budget: cycle %0d beyond limit %0d", cyc, MAXC);
        $fatal(1);
      end
      if (!sw[17]) begin
        lv3 = 1'b1;
        lv2 = 1'b1;
        m_loaded = 1'b0;
        mq.delete();
        m_pat = '0;
        m_ser = 1'b0;
        clk_start = -100;
      end else begin
        h3[cyc] = key[3];
        h2[cyc] = key[2];
        n = cyc - 1;
        p3 = 1'b0;
        p2 = 1'b0;
        if (settled(n, lv3, 1'b1)) begin
          lv3 = ~lv3;
          p3 = !lv3;
        end
        if (settled(n, lv2, 1'b0)) begin
          lv2 = ~lv2;
          p2 = !lv2;
        end
        if (p2) begin
          m_loaded = 1'b1;
          m_pat = sw[7:0];
          mq.delete();
          for (int i = 7; i >= 0; i--) mq.push_back(sw[i]);
        end else if (p3 && m_loaded &&
                     !(n >= clk_start - 1 && n < clk_start + SH)) begin
          if (mq.size() == 0 && sw[8])
            for (int i = 7; i >= 0; i--) mq.push_back(m_pat[i]);
          if (mq.size() > 0) begin
            m_ser = mq.pop_front();
            clk_start = cyc + 1;
          end
        end
      end
    end
  end

  int rises     = 0;
  int hi_len    = 0;
  int hi_cur    = 0;
  int last_rise = 0;
  bit prev_clk  = 1'b0;

  initial forever begin
    logic        e_clk;
    logic [17:0] e_led;
    @(negedge clk);
    e_clk = (cyc >= clk_start) && (cyc < clk_start + SH);
    e_led = {m_loaded && mq.size() == 0, e_clk, 4'b0000,
             4'(mq.size()), m_sh()};
    chk("cyc ser_out", ser_out, m_ser);
    chk("cyc step_clk", step_clk, e_clk);
    chk("cyc LEDR", ledr, e_led);
    if (step_clk && !prev_clk) begin
      rises++;
      last_rise = cyc;
    end
    if (step_clk) hi_cur++;
    else if (prev_clk) begin
      hi_len = hi_cur;
      hi_cur = 0;
    end
    prev_clk = step_clk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input int b);
    key[b] = 1'b0;
    tick(10);
    key[b] = 1'b1;
    tick(12);
  endtask

  initial begin
    int r0;
    int c0;
    int exp_seq[8];
    exp_seq = '{0, 1, 0, 0, 0, 1, 0, 1};
    sw  = 18'h20000;
    key = 4'hF;
    #1 sw[17] = 1'b0;
    tick(3);
    chk("reset LEDR", ledr, 0);
    chk("reset ser_out", ser_out, 0);
    chk("reset step_clk", step_clk, 0);
    sw[17] = 1'b1;
    tick(2);

    // step held in EMPTY
    r0 = rises;
    key[3] = 1'b0;
    tick(20);
    chk("t1 no step_clk", rises - r0, 0);
    chk("t1 ser_out", ser_out, 0);
    chk("t1 LEDR", ledr, 0);
    key[3] = 1'b1;
    tick(10);

    // load 0x45 and shift it out
    sw[7:0] = 8'b01000101;
    press(2);
    chk("t2 load shreg", ledr[7:0], 8'h45);
    chk("t2 load left", ledr[11:8], 8);
    chk("t2 model left", mq.size(), 8);
    for (int k = 0; k < 8; k++) begin
      r0 = rises;
      press(3);
      chk($sformatf("t2 bit%0d", k), ser_out, exp_seq[k]);
      chk($sformatf("t2 rise%0d", k), rises - r0, 1);
      chk($sformatf("t2 width%0d", k), hi_len, SH);
    end
    chk("t2 left", ledr[11:8], 0);
    chk("t2 done", ledr[17], 1);
    chk("t2 model ser", m_ser, 1);

    // DONE without and with loop mode
    sw[8] = 1'b0;
    r0 = rises;
    press(3);
    chk("t4 noloop rise", rises - r0, 0);
    chk("t4 noloop done", ledr[17], 1);
    chk("t4 noloop ser", ser_out, 1);
    sw[8] = 1'b1;
    r0 = rises;
    press(3);
    chk("t4 loop ser", ser_out, 0);
    chk("t4 loop left", ledr[11:8], 7);
    chk("t4 loop ready", ledr[17], 0);
    chk("t4 loop shreg", ledr[7:0], 8'h8A);
    chk("t4 loop rise", rises - r0, 1);

    // bouncing step key, ending low
    r0 = rises;
    for (int i = 0; i < 7; i++) begin
      key[3] = ~key[3];
      if (i < 6) tick(2);
    end
    c0 = cyc;
    tick(DEB + 6);
    chk("t3 one step", rises - r0, 1);
    chk("t3 latency", last_rise - c0, DEB + 3);
    chk("t3 ser", ser_out, 1);
    chk("t3 left", ledr[11:8], 6);
    key[3] = 1'b1;
    tick(12);

    // simultaneous load and step
    sw[7:0] = 8'hA5;
    r0 = rises;
    key[3] = 1'b0;
    key[2] = 1'b0;
    tick(10);
    key = 4'hF;
    tick(12);
    chk("t5 shreg", ledr[7:0], 8'hA5);
    chk("t5 left", ledr[11:8], 8);
    chk("t5 ser kept", ser_out, 1);
    chk("t5 no rise", rises - r0, 0);

    // reset during a step_clk pulse
    key[3] = 1'b0;
    for (int i = 0; i < 20 && !step_clk; i++) tick(1);
    chk("t6 step_clk high", step_clk, 1);
    chk("t6 ser before", ser_out, 1);
    #1 sw[17] = 1'b0;
    #1;
    chk("t6 async step_clk", step_clk, 0);
    chk("t6 async ser", ser_out, 0);
    chk("t6 async LEDR", ledr, 0);
    tick(3);
    r0 = rises;
    sw[17] = 1'b1;
    tick(15);
    key[3] = 1'b1;
    tick(8);
    key[3] = 1'b0;
    tick(10);
    key[3] = 1'b1;
    tick(10);
    chk("t6 empty rise", rises - r0, 0);
    chk("t6 empty LEDR", ledr, 0);
    chk("t6 empty ser", ser_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
